measurement_round_loader: RTL and testbench

Front-end controller between the 8-bit syndrome byte stream and the decoding graph's per-round measurement port. It unpacks bytes into measurement rounds and buffers them in a round FIFO. On a controller `load_start` it replays exactly one decoding block, `ROUNDS_PER_BLOCK` rounds on consecutive cycles, into the graph. It also applies input backpressure so no round is ever dropped.

---
 rtl/measurement_round_loader.sv | 217 +++++++++++++++++++++
 tb/tb_measurement_round_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/measurement_round_loader.sv
// measurement_round_loader
//   Unpacks the 8-bit syndrome byte stream into measurement rounds and
//   buffers them in a round FIFO. A load_start replays one decoding block
//   (ROUNDS_PER_BLOCK rounds on consecutive cycles) into the decoding graph.
//
// Ports
//   clk               sole clock, rising edge
//   reset             asynchronous, active-high
//   input_data        syndrome byte
//   input_valid       byte valid
//   input_ready       byte accepted when valid && ready (registered)
//   flush             synchronous clear of FIFO, unpacker and load
//   load_start        request one block
//   measurements      round data to the graph (holds when not valid)
//   measurement_valid measurements valid this cycle
//   round_index       index of the presented round within the block
//   load_done         one-cycle pulse with the last round of a block
//   busy              load in progress (not set on the last round)
//   block_available   fifo_count >= ROUNDS_PER_BLOCK
//   fifo_count        rounds buffered
module measurement_round_loader #(
  parameter int ROUND_BITS       = 4,
  parameter int ROUNDS_PER_BLOCK = 3,
  parameter int FIFO_DEPTH       = 4,
  localparam int BYTES_PER_ROUND = (ROUND_BITS + 7) / 8,
  localparam int CW              = $clog2(FIFO_DEPTH + 1),
  localparam int IW              = (ROUNDS_PER_BLOCK > 1) ? $clog2(ROUNDS_PER_BLOCK) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            input_data,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic                  flush,
  input  logic                  load_start,
  output logic [ROUND_BITS-1:0] measurements,
  output logic                  measurement_valid,
  output logic [IW-1:0]         round_index,
  output logic                  load_done,
  output logic                  busy,
  output logic                  block_available,
  output logic [CW-1:0]         fifo_count
);

  localparam int BW = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_LOAD
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         pop_cnt_q, pop_cnt_d;
  logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [ROUND_BITS-1:0] asm_q, asm_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q, ready_d;
  logic [ROUND_BITS-1:0] meas_q, meas_d;
  logic                  mvalid_q, mvalid_d;
  logic [IW-1:0]         ridx_q, ridx_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [ROUND_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                  accept;
  logic                  last_byte;
  logic                  push;
  logic                  pop;
  logic                  start;
  logic                  blk_avail;
  logic [ROUND_BITS-1:0] round_w;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    accept    = input_valid && ready_q;
    last_byte = (byte_cnt_q == BW'(BYTES_PER_ROUND - 1));

    // Current byte lands in lane byte_cnt_q; earlier lanes come from the
    // assembly register. Bits at or above ROUND_BITS simply never exist.
    round_w = asm_q;
    for (int i = 0; i < ROUND_BITS; i++) begin
      if ((i / 8) == int'(byte_cnt_q)) begin
        round_w[i] = input_data[i % 8];
      end
    end

    push      = accept && last_byte;
    blk_avail = (count_q >= CW'(ROUNDS_PER_BLOCK));
    start     = (state_q == S_IDLE) && load_start && blk_avail;
    pop       = start || (state_q == S_LOAD);

    state_d    = state_q;
    pop_cnt_d  = pop_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    meas_d     = meas_q;
    mvalid_d   = 1'b0;
    ridx_d     = ridx_q;
    done_d     = 1'b0;
    busy_d     = busy_q;

    if (accept) begin
      byte_cnt_d = last_byte ? '0 : byte_cnt_q + BW'(1);
      asm_d      = round_w;
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      meas_d   = mem_q[rd_ptr_q];
      mvalid_d = 1'b1;
    end

    if (start) begin
      ridx_d = '0;
      if (ROUNDS_PER_BLOCK == 1) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        state_d   = S_LOAD;
        pop_cnt_d = IW'(1);
        busy_d    = 1'b1;
      end
    end else if (state_q == S_LOAD) begin
      ridx_d = pop_cnt_q;
      if (pop_cnt_q == IW'(ROUNDS_PER_BLOCK - 1)) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        pop_cnt_d = pop_cnt_q + IW'(1);
      end
    end

    // Ready looks one edge ahead so a full FIFO never sees a push.
    ready_d = (count_d != CW'(FIFO_DEPTH));

    if (flush) begin
      state_d    = S_IDLE;
      pop_cnt_d  = '0;
      byte_cnt_d = '0;
      asm_d      = asm_q;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      meas_d     = meas_q;
      ridx_d     = ridx_q;
      mvalid_d   = 1'b0;
      done_d     = 1'b0;
      busy_d     = 1'b0;
      ready_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pop_cnt_q  <= '0;
      byte_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      meas_q     <= '0;
      mvalid_q   <= 1'b0;
      ridx_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_cnt_q  <= pop_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      meas_q     <= meas_d;
      mvalid_q   <= mvalid_d;
      ridx_q     <= ridx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Round storage and partial-round bytes carry no control meaning, so
  // they are left out of reset; the counters above decide what is live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= round_w;
    asm_q <= asm_d;
  end

  assign input_ready       = ready_q;
  assign measurements      = meas_q;
  assign measurement_valid = mvalid_q;
  assign round_index       = ridx_q;
  assign load_done         = done_q;
  assign busy              = busy_q;
  assign block_available   = blk_avail;
  assign fifo_count        = count_q;

endmodule

// File: tb/tb_measurement_round_loader.sv
module tb_measurement_round_loader;

  localparam int RPB   = 3;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] input_data;
  logic       input_valid;
  logic       input_ready;
  logic       flush;
  logic       load_start;
  logic [3:0] measurements;
  logic       measurement_valid;
  logic [1:0] round_index;
  logic       load_done;
  logic       busy;
  logic       block_available;
  logic [2:0] fifo_count;

  // Second instance: 12-bit rounds (two bytes each), single-round blocks.
  logic [7:0]  b_data;
  logic        b_valid;
  logic        b_ready;
  logic        b_flush;
  logic        b_load;
  logic [11:0] b_meas;
  logic        b_mvalid;
  logic [0:0]  b_ridx;
  logic        b_done;
  logic        b_busy;
  logic        b_avail;
  logic [1:0]  b_count;

  measurement_round_loader #(
    .ROUND_BITS(4), .ROUNDS_PER_BLOCK(RPB), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .reset(reset), .input_data(input_data), .input_valid(input_valid),
    .input_ready(input_ready), .flush(flush), .load_start(load_start),
    .measurements(measurements), .measurement_valid(measurement_valid),
    .round_index(round_index), .load_done(load_done), .busy(busy),
    .block_available(block_available), .fifo_count(fifo_count)
  );

  measurement_round_loader #(
    .ROUND_BITS(12), .ROUNDS_PER_BLOCK(1), .FIFO_DEPTH(2)
  ) u_dut_b (
    .clk(clk), .reset(reset), .input_data(b_data), .input_valid(b_valid),
    .input_ready(b_ready), .flush(b_flush), .load_start(b_load),
    .measurements(b_meas), .measurement_valid(b_mvalid),
    .round_index(b_ridx), .load_done(b_done), .busy(b_busy),
    .block_available(b_avail), .fifo_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered rounds plus the block being replayed.
  logic [3:0] mq[$];
  bit         m_ready;
  bit         m_load;
  int         m_k;
  logic [3:0] m_meas;
  bit         m_valid;
  bit         m_done;
  bit         m_busy;
  int         m_idx;

  task automatic model_reset();
    mq.delete();
    m_ready = 0; m_load = 0; m_k = 0;
    m_meas = '0; m_valid = 0; m_done = 0; m_busy = 0; m_idx = 0;
  endtask

  // Applies one clock edge of the spec's rules using the inputs sampled at it.
  task automatic model_edge();
    bit popped;
    if (flush) begin
      mq.delete();
      m_ready = 1; m_load = 0; m_valid = 0; m_done = 0; m_busy = 0;
      return;
    end
    popped = 0;
    if (m_load) begin
      m_k++;
      popped = 1;
    end else if (load_start && mq.size() >= RPB) begin
      m_load = 1;
      m_k = 0;
      popped = 1;
    end
    if (popped) begin
      m_meas  = mq.pop_front();
      m_valid = 1;
      m_idx   = m_k;
      m_done  = (m_k == RPB - 1);
      m_busy  = !m_done;
      if (m_done) m_load = 0;
    end else begin
      m_valid = 0; m_done = 0; m_busy = 0;
    end
    if (input_valid && m_ready) mq.push_back(input_data[3:0]);
    m_ready = (mq.size() < DEPTH);
  endtask

  task automatic compare_all();
    check("input_ready", 32'(input_ready), 32'(m_ready));
    check("measurement_valid", 32'(measurement_valid), 32'(m_valid));
    check("measurements", 32'(measurements), 32'(m_meas));
    if (m_valid) check("round_index", 32'(round_index), 32'(m_idx));
    check("load_done", 32'(load_done), 32'(m_done));
    check("busy", 32'(busy), 32'(m_busy));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("block_available", 32'(block_available), 32'(mq.size() >= RPB));
  endtask

  task automatic step();
    if (!reset && !flush) begin
      if (input_valid && input_ready) check("push_room", 32'(fifo_count < 3'(DEPTH)), 32'd1);
      if (busy || (load_start && block_available)) check("pop_nonempty", 32'(fifo_count != 0), 32'd1);
    end
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic send(input logic [7:0] d);
    input_valid = 1'b1;
    input_data  = d;
    step();
    input_valid = 1'b0;
  endtask

  int vcnt;
  int dcnt;
  int sent;

  initial begin
    reset = 1'b1;
    input_data = '0; input_valid = 0; flush = 0; load_start = 0;
    b_data = '0; b_valid = 0; b_flush = 0; b_load = 0;
    #2;
    model_reset();
    compare_all();
    check("b_reset_ready", 32'(b_ready), 32'd0);
    check("b_reset_meas", 32'(b_meas), 32'd0);
    check("b_reset_count", 32'(b_count), 32'd0);
    step();
    step();
    reset = 1'b0;
    check("ready_low_after_release", 32'(input_ready), 32'd0);
    step();
    check("ready_rises", 32'(input_ready), 32'd1);
    check("b_ready_rises", 32'(b_ready), 32'd1);

    // 12-bit rounds: upper nibble of the second byte is discarded.
    b_valid = 1; b_data = 8'h34; step();
    b_data = 8'hF2; step();
    b_valid = 0;
    check("b_count_one", 32'(b_count), 32'd1);
    b_load = 1; step(); b_load = 0;
    check("b_meas_234", 32'(b_meas), 32'h234);
    check("b_valid", 32'(b_mvalid), 32'd1);
    check("b_done_single", 32'(b_done), 32'd1);
    check("b_busy_never", 32'(b_busy), 32'd0);
    check("b_count_zero", 32'(b_count), 32'd0);
    step();
    check("b_valid_drop", 32'(b_mvalid), 32'd0);
    check("b_meas_hold", 32'(b_meas), 32'h234);
    // Partial byte then flush: next two bytes form a fresh round.
    b_valid = 1; b_data = 8'h11; step();
    b_valid = 0; b_flush = 1; step(); b_flush = 0;
    check("b_flush_count", 32'(b_count), 32'd0);
    check("b_flush_ready", 32'(b_ready), 32'd1);
    b_valid = 1; b_data = 8'hAB; step();
    b_data = 8'h0C; step();
    b_valid = 0;
    b_load = 1; step(); b_load = 0;
    check("b_meas_fresh", 32'(b_meas), 32'hCAB);

    // Basic block replay.
    send(8'h13); send(8'hA5); send(8'h0C);
    load_start = 1; step(); load_start = 0;
    check("blk_r0", 32'(measurements), 32'h3);
    check("blk_i0", 32'(round_index), 32'd0);
    step();
    check("blk_r1", 32'(measurements), 32'h5);
    step();
    check("blk_r2", 32'(measurements), 32'hC);
    check("blk_done", 32'(load_done), 32'd1);
    check("blk_count", 32'(fifo_count), 32'd0);
    step();

    // Backpressure: fifth byte waits until a load frees space.
    input_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      input_data = 8'(i);
      step();
    end
    input_data = 8'h07;
    check("full_ready_low", 32'(input_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd4);
    step(); step(); step();
    check("full_hold_count", 32'(fifo_count), 32'd4);
    load_start = 1; step(); load_start = 0;
    step();
    input_valid = 0;
    step();
    send(8'h08);
    load_start = 1; step(); load_start = 0;
    check("next_block_4th", 32'(measurements), 32'h4);
    step(); step(); step();

    // Two rounds are not a block; a third round enables the load.
    send(8'h09); send(8'h0A);
    load_start = 1; step(); load_start = 0;
    check("no_start_on_2", 32'(measurement_valid), 32'd0);
    step();
    send(8'h0B);
    load_start = 1; step(); load_start = 0;
    check("late_r0", 32'(measurements), 32'h9);
    step(); step(); step();

    // Six rounds, load_start held: two blocks back to back.
    send(8'h0D); send(8'h0E); send(8'h0F); send(8'h01);
    vcnt = 0; dcnt = 0; sent = 0;
    for (int c = 0; c < 8; c++) begin
      load_start  = 1;
      input_valid = (sent < 2);
      input_data  = 8'(2 + sent);
      if (input_valid && m_ready) sent++;
      step();
      if (measurement_valid) vcnt++;
      if (load_done) dcnt++;
    end
    load_start = 0; input_valid = 0;
    check("b2b_valid_cycles", 32'(vcnt), 32'd6);
    check("b2b_done_pulses", 32'(dcnt), 32'd2);
    step();

    // Reset in cycle 2 of a load.
    send(8'h05); send(8'h06); send(8'h07);
    load_start = 1; step(); load_start = 0;
    step();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    step(); step();
    reset = 1'b0;
    check("rst_ready_low", 32'(input_ready), 32'd0);
    step();
    check("rst_ready_rise", 32'(input_ready), 32'd1);
    check("rst_no_done", 32'(load_done), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      input_valid = (($urandom % 4) != 0);
      input_data  = 8'($urandom);
      load_start  = (($urandom % 3) == 0);
      flush       = (($urandom % 64) == 0);
      step();
      flush = 0;
      if (($urandom % 400) == 0) do_reset();
    end
    input_valid = 0; load_start = 0; flush = 0;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
